data_mem_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the 64x8 data RAM.
- Accepts one load or store request from the pipeline and computes the effective address as base + signed offset.
- Range-checks the address, drives the RAM's address, write-data and write-enable inputs, and returns load data or an error over a valid/ready response channel.
- Non-pipelined: one transaction in flight at a time.

---
 rtl/data_mem_lsu_if.sv | 28 ++
 rtl/data_mem_lsu.sv | 117 +++++++++++
 tb/tb_data_mem_lsu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: pipeline-side request/response channels of the load/store unit.
//   master: pipeline drives req_* and resp_ready, observes req_ready and resp_*.
//   slave : LSU observes req_* and resp_ready, drives req_ready and resp_*.
interface data_mem_lsu_if #(
    parameter int DATA_WIDTH = 8,
    parameter int EA_WIDTH   = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [EA_WIDTH-1:0]   req_base;
    logic [EA_WIDTH-1:0]   req_offset;
    logic [DATA_WIDTH-1:0] req_store_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    modport master (
        output req_valid, req_is_store, req_base, req_offset, req_store_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_is_store, req_base, req_offset, req_store_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: non-pipelined load/store unit in front of a 64x8 registered-read RAM.
//   clk, rst_n          : clock and asynchronous active-low reset
//   lsu (slave)         : request channel (base + signed offset) and valid/ready response
//   mem_address_o       : RAM address
//   mem_write_data_o    : RAM write data
//   mem_write_enable_o  : RAM write enable, one cycle per store
//   mem_read_data_i     : RAM read data, one cycle after the address
//   err_count_o         : saturating count of out-of-range responses
module data_mem_lsu #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int EA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_lsu_if.slave         lsu,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    output logic                  mem_write_enable_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i,
    output logic [7:0]            err_count_o
);
    typedef enum logic [2:0] {IDLE, STORE, LD_WAIT, LD_CAPT, RESP} state_t;

    state_t                state_q, state_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [EA_WIDTH-1:0]   ea;
    logic                  oor;

    // Effective address wraps modulo 2^EA_WIDTH; any bit above the RAM index is out of range.
    assign ea  = lsu.req_base + lsu.req_offset;
    assign oor = |ea[EA_WIDTH-1:ADDR_WIDTH];

    assign lsu.req_ready     = (state_q == IDLE);
    assign lsu.resp_valid    = resp_valid_q;
    assign lsu.resp_data     = resp_data_q;
    assign lsu.resp_err      = resp_err_q;
    assign mem_address_o     = mem_addr_q;
    assign mem_write_data_o  = mem_wdata_q;
    assign mem_write_enable_o = mem_we_q;
    assign err_count_o       = err_cnt_q;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        err_cnt_d    = err_cnt_q;
        case (state_q)
            IDLE: if (lsu.req_valid) begin
                if (oor) begin
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                    resp_valid_d = 1'b1;
                    err_cnt_d    = &err_cnt_q ? err_cnt_q : err_cnt_q + 8'd1;
                    state_d      = RESP;
                end else begin
                    mem_addr_d = ea[ADDR_WIDTH-1:0];
                    mem_we_d   = lsu.req_is_store;
                    if (lsu.req_is_store)
                        mem_wdata_d = lsu.req_store_data;
                    state_d = lsu.req_is_store ? STORE : LD_WAIT;
                end
            end
            STORE: begin
                mem_we_d     = 1'b0;
                resp_data_d  = '0;
                resp_err_d   = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            LD_WAIT: state_d = LD_CAPT;
            LD_CAPT: begin
                resp_data_d  = mem_read_data_i;
                resp_err_d   = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: if (lsu.resp_ready) begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            err_cnt_q    <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: randomized self-checking bench for data_mem_lsu with a 64x8 RAM model.
module tb_data_mem_lsu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] mem_address;
    logic [7:0] mem_write_data;
    logic       mem_write_enable;
    logic [7:0] mem_read_data;
    logic [7:0] err_count;

    logic [7:0] ram [64];
    logic [7:0] init_img [64];
    logic       preload = 1'b0;
    logic [7:0] model_mem [64];
    int         exp_err = 0;
    int         checks = 0;
    int         errors = 0;

    data_mem_lsu_if #(.DATA_WIDTH(8), .EA_WIDTH(8)) bus ();

    data_mem_lsu #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .EA_WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lsu(bus),
        .mem_address_o(mem_address),
        .mem_write_data_o(mem_write_data),
        .mem_write_enable_o(mem_write_enable),
        .mem_read_data_i(mem_read_data),
        .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_img[i];
        end else begin
            if (mem_write_enable) ram[mem_address] <= mem_write_data;
            mem_read_data <= ram[mem_address];
        end
    end

    // Runs one transaction and reports what was observed; expectations live in the callers.
    task automatic issue(input bit st, input logic [7:0] b, input logic [7:0] o, input logic [7:0] d,
                         input int stall, output int lat, output logic [7:0] rd, output logic re,
                         output int wes, output logic [5:0] wa, output bit hold_ok, output bit done_ok);
        int n;
        hold_ok = 1'b1; done_ok = 1'b1; wes = 0; wa = '0; n = 0;
        while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
        bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_base = b;
        bus.req_offset = o; bus.req_store_data = d; bus.resp_ready = (stall == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            if (mem_write_enable) begin wes++; wa = mem_address; end
            @(posedge clk); #1;
            lat++;
        end
        if (mem_write_enable) wes++;
        if (!bus.resp_valid) lat = -1;
        rd = bus.resp_data; re = bus.resp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!bus.resp_valid || bus.resp_data !== rd || bus.resp_err !== re || bus.req_ready || mem_write_enable)
                hold_ok = 1'b0;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        done_ok = !bus.resp_valid && bus.req_ready;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_base = 8'h01;
        bus.req_offset = 8'h01; bus.req_store_data = 8'hFF; bus.resp_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin init_img[i] = 8'($urandom); model_mem[i] = init_img[i]; end
        preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", mem_write_enable); end
        checks++; if (mem_address !== 6'd0 || mem_write_data !== 8'd0) begin errors++; $display("FAIL reset_mem got %h/%h want 0/0", mem_address, mem_write_data); end
        checks++; if (err_count !== 8'd0 || bus.resp_data !== 8'd0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got cnt=%0d data=%h err=%b want 0", err_count, bus.resp_data, bus.resp_err); end
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        int lat, wes; logic [7:0] rd; logic re; logic [5:0] wa; bit h, dn;
        issue(1'b1, 8'h10, 8'h05, 8'hA5, 0, lat, rd, re, wes, wa, h, dn);
        model_mem[6'h15] = 8'hA5;
        checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency got %0d want 2", lat); end
        checks++; if (wes !== 1 || wa !== 6'h15) begin errors++; $display("FAIL store_we got cycles=%0d addr=%h want 1/15", wes, wa); end
        checks++; if (rd !== 8'h00 || re !== 1'b0) begin errors++; $display("FAIL store_resp got %h/%b want 00/0", rd, re); end
        checks++; if (!dn) begin errors++; $display("FAIL store_done got 0 want 1"); end
        issue(1'b0, 8'h10, 8'h05, 8'h00, 0, lat, rd, re, wes, wa, h, dn);
        checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
        checks++; if (rd !== 8'hA5 || re !== 1'b0 || wes !== 0) begin errors++; $display("FAIL load_resp got %h/%b we=%0d want a5/0/0", rd, re, wes); end
    endtask

    task automatic test_out_of_range;
        int lat, wes; logic [7:0] rd; logic re; logic [5:0] wa; bit h, dn;
        issue(1'b0, 8'h3F, 8'h01, 8'h00, 0, lat, rd, re, wes, wa, h, dn);
        exp_err++;
        checks++; if (lat !== 1 || re !== 1'b1 || rd !== 8'h00) begin errors++; $display("FAIL oor_resp got lat=%0d err=%b data=%h want 1/1/00", lat, re, rd); end
        checks++; if (wes !== 0 || err_count !== 8'(exp_err)) begin errors++; $display("FAIL oor_count got we=%0d cnt=%0d want 0/%0d", wes, err_count, exp_err); end
        issue(1'b1, 8'h3F, 8'h40, 8'h77, 0, lat, rd, re, wes, wa, h, dn);
        exp_err++;
        checks++; if (wes !== 0 || re !== 1'b1) begin errors++; $display("FAIL oor_store got we=%0d err=%b want 0/1", wes, re); end
        issue(1'b0, 8'h3F, 8'h00, 8'h00, 0, lat, rd, re, wes, wa, h, dn);
        checks++; if (re !== 1'b0 || rd !== model_mem[63] || lat !== 3) begin errors++; $display("FAIL ea63 got err=%b data=%h lat=%0d want 0/%h/3", re, rd, lat, model_mem[63]); end
    endtask

    task automatic test_neg_offset;
        int lat, wes; logic [7:0] rd; logic re; logic [5:0] wa; bit h, dn;
        issue(1'b1, 8'h00, 8'h03, 8'h3C, 0, lat, rd, re, wes, wa, h, dn);
        model_mem[3] = 8'h3C;
        issue(1'b0, 8'h05, 8'hFE, 8'h00, 0, lat, rd, re, wes, wa, h, dn);
        checks++; if (mem_address !== 6'h03) begin errors++; $display("FAIL neg_addr got %h want 03", mem_address); end
        checks++; if (rd !== 8'h3C || re !== 1'b0) begin errors++; $display("FAIL neg_resp got %h/%b want 3c/0", rd, re); end
    endtask

    task automatic test_backpressure;
        int lat, wes; logic [7:0] rd; logic re; logic [5:0] wa; bit h, dn;
        issue(1'b0, 8'h20, 8'h09, 8'h00, 5, lat, rd, re, wes, wa, h, dn);
        checks++; if (!h) begin errors++; $display("FAIL bp_hold got unstable want stable"); end
        checks++; if (!dn) begin errors++; $display("FAIL bp_done got busy want idle"); end
        checks++; if (rd !== model_mem[6'h29] || lat !== 3) begin errors++; $display("FAIL bp_data got %h lat=%0d want %h/3", rd, lat, model_mem[6'h29]); end
    endtask

    task automatic test_random;
        int lat, wes, elat; logic [7:0] rd, b, o, d, ea; logic re; logic [5:0] wa; bit h, dn, st, eerr;
        for (int k = 0; k < 60; k++) begin
            st = 1'($urandom);
            b = 8'($urandom_range(0, 90));
            o = 8'($urandom_range(0, 60) - 30);
            d = 8'($urandom);
            ea = b + o;
            eerr = (ea > 8'd63);
            elat = eerr ? 1 : (st ? 2 : 3);
            issue(st, b, o, d, $urandom_range(0, 2), lat, rd, re, wes, wa, h, dn);
            checks++;
            if (lat !== elat || re !== eerr || rd !== ((eerr || st) ? 8'h00 : model_mem[ea[5:0]])
                || wes !== ((st && !eerr) ? 1 : 0) || (st && !eerr && wa !== ea[5:0]) || !h || !dn) begin
                errors++;
                $display("FAIL rand_txn%0d got lat=%0d err=%b data=%h we=%0d wa=%h want lat=%0d err=%b data=%h ea=%h",
                         k, lat, re, rd, wes, wa, elat, eerr, (eerr || st) ? 8'h00 : model_mem[ea[5:0]], ea);
            end
            if (eerr) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            else if (st) model_mem[ea[5:0]] = d;
        end
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL rand_count got %0d want %0d", err_count, exp_err); end
    endtask

    task automatic test_reset_store;
        int lat, wes; logic [7:0] rd; logic re; logic [5:0] wa; bit h, dn, quiet;
        bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_base = 8'h20;
        bus.req_offset = 8'h07; bus.req_store_data = ~model_mem[6'h27]; bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++; if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL rst_store_we got %b want 1", mem_write_enable); end
        rst_n = 1'b0;
        #1;
        exp_err = 0;
        checks++; if (mem_write_enable !== 1'b0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_async got we=%b rv=%b want 0/0", mem_write_enable, bus.resp_valid); end
        checks++; if (err_count !== 8'd0 || mem_address !== 6'd0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_values got cnt=%0d addr=%h rdy=%b want 0/0/1", err_count, mem_address, bus.req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (4) begin @(posedge clk); #1; if (bus.resp_valid !== 1'b0) quiet = 1'b0; end
        checks++; if (!quiet) begin errors++; $display("FAIL rst_no_resp got resp_valid=1 want 0"); end
        issue(1'b0, 8'h27, 8'h00, 8'h00, 0, lat, rd, re, wes, wa, h, dn);
        checks++; if (rd !== model_mem[6'h27] || re !== 1'b0) begin errors++; $display("FAIL rst_ram got %h want %h", rd, model_mem[6'h27]); end
    endtask

    task automatic test_saturation;
        int lat, wes; logic [7:0] rd; logic re; logic [5:0] wa; bit h, dn;
        for (int k = 0; k < 257; k++) begin
            issue(1'($urandom), 8'($urandom_range(64, 255)), 8'h00, 8'($urandom), 0, lat, rd, re, wes, wa, h, dn);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            if (k == 254) begin
                checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", err_count); end
            end
        end
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL sat_hold got %0d want %0d", err_count, exp_err); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_base = '0;
        bus.req_offset = '0; bus.req_store_data = '0; bus.resp_ready = 1'b0;
        test_reset;
        test_store_load;
        test_out_of_range;
        test_neg_offset;
        test_backpressure;
        test_random;
        test_reset_store;
        test_saturation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
